// File: rtl/alu_8bit_arbiter.sv
// rtl/alu_8bit_arbiter.sv - round-robin arbiter/sequencer sharing one registered 8-bit ALU
// Optional grant statistics enabled by defining ALU_ARB_STATS_EN.
module alu_8bit_arbiter #(
  parameter int ALU_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_overflow,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_overflow,
  output logic       busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic       last_grant;
  logic       grant;
  logic       sel;
  logic [2:0] cnt;
  logic       accept;
  logic       rsp_hs;

  // Candidate winner: the sole valid requester, or the one not served last on a tie.
  always_comb begin
    sel = req1_valid;
    if (req0_valid && req1_valid) sel = ~last_grant;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !sel;
  assign req1_ready = (state == IDLE) && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;
  assign rsp0_valid = (state == RESP) && !grant;
  assign rsp1_valid = (state == RESP) && grant;
  assign rsp_hs     = (state == RESP) && (grant ? rsp1_ready : rsp0_ready);
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 3'd0) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      grant        <= 1'b0;
      cnt          <= 3'd0;
      alu_a        <= 8'h00;
      alu_b        <= 8'h00;
      alu_op       <= 2'b00;
      rsp_result   <= 8'h00;
      rsp_carry    <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        alu_a  <= sel ? req1_a  : req0_a;
        alu_b  <= sel ? req1_b  : req0_b;
        alu_op <= sel ? req1_op : req0_op;
        grant  <= sel;
      end
      if (state == ISSUE) cnt <= 3'(ALU_LATENCY - 1);
      if (state == WAIT) begin
        if (cnt == 3'd0) begin
          rsp_result   <= alu_result;
          rsp_carry    <= alu_carry;
          rsp_zero     <= alu_zero;
          rsp_overflow <= alu_overflow;
        end else begin
          cnt <= cnt - 3'd1;
        end
      end
      if (rsp_hs) last_grant <= grant;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= 16'h0000;
      grant_cnt1 <= 16'h0000;
    end else begin
      if (req0_ready && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_8bit_arbiter.sv
// tb/tb_alu_8bit_arbiter.sv - directed bench for alu_8bit_arbiter
// Instance 0 uses ALU_LATENCY=1, instance 1 uses ALU_LATENCY=3.
module tb_alu_8bit_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0] req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0] rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [1:0] rsp_carry, rsp_zero, rsp_overflow, busy;
  logic [1:0] alu_carry, alu_zero, alu_overflow;
  logic [7:0] req0_a [2], req0_b [2], req1_a [2], req1_b [2];
  logic [1:0] req0_op [2], req1_op [2], alu_op [2];
  logic [7:0] rsp_result [2], alu_a [2], alu_b [2], alu_result [2];
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0 [2], grant_cnt1 [2];
`endif

  alu_8bit_arbiter #(.ALU_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid[0]), .req0_ready(req0_ready[0]), .req0_a(req0_a[0]), .req0_b(req0_b[0]), .req0_op(req0_op[0]),
    .req1_valid(req1_valid[0]), .req1_ready(req1_ready[0]), .req1_a(req1_a[0]), .req1_b(req1_b[0]), .req1_op(req1_op[0]),
    .rsp0_valid(rsp0_valid[0]), .rsp0_ready(rsp0_ready[0]), .rsp1_valid(rsp1_valid[0]), .rsp1_ready(rsp1_ready[0]),
    .rsp_result(rsp_result[0]), .rsp_carry(rsp_carry[0]), .rsp_zero(rsp_zero[0]), .rsp_overflow(rsp_overflow[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_result(alu_result[0]),
    .alu_carry(alu_carry[0]), .alu_zero(alu_zero[0]), .alu_overflow(alu_overflow[0]), .busy(busy[0])
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0[0]), .grant_cnt1(grant_cnt1[0])
`endif
  );

  alu_8bit_arbiter #(.ALU_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid[1]), .req0_ready(req0_ready[1]), .req0_a(req0_a[1]), .req0_b(req0_b[1]), .req0_op(req0_op[1]),
    .req1_valid(req1_valid[1]), .req1_ready(req1_ready[1]), .req1_a(req1_a[1]), .req1_b(req1_b[1]), .req1_op(req1_op[1]),
    .rsp0_valid(rsp0_valid[1]), .rsp0_ready(rsp0_ready[1]), .rsp1_valid(rsp1_valid[1]), .rsp1_ready(rsp1_ready[1]),
    .rsp_result(rsp_result[1]), .rsp_carry(rsp_carry[1]), .rsp_zero(rsp_zero[1]), .rsp_overflow(rsp_overflow[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_result(alu_result[1]),
    .alu_carry(alu_carry[1]), .alu_zero(alu_zero[1]), .alu_overflow(alu_overflow[1]), .busy(busy[1])
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0[1]), .grant_cnt1(grant_cnt1[1])
`endif
  );

  // Registered ALU stand-ins: {carry, zero, overflow, result}
  function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [8:0] s;
    logic       v;
    s = 9'h0;
    v = 1'b0;
    case (op)
      2'b00: begin s = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (s[7] != a[7]); end
      2'b01: begin s = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (s[7] != a[7]); end
      2'b10: s = {1'b0, a & b};
      default: s = {1'b0, a | b};
    endcase
    return {s[8], (s[7:0] == 8'h00), v, s[7:0]};
  endfunction

  logic [10:0] p0;
  logic [10:0] p1 [3];
  always_ff @(posedge clk) begin
    p0    <= alu_f(alu_a[0], alu_b[0], alu_op[0]);
    p1[0] <= alu_f(alu_a[1], alu_b[1], alu_op[1]);
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign {alu_carry[0], alu_zero[0], alu_overflow[0], alu_result[0]} = p0;
  assign {alu_carry[1], alu_zero[1], alu_overflow[1], alu_result[1]} = p1[2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input int d, input bit s, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic [1:0] op);
    if (s) begin req1_valid[d] = v; req1_a[d] = a; req1_b[d] = b; req1_op[d] = op; end
    else   begin req0_valid[d] = v; req0_a[d] = a; req0_b[d] = b; req0_op[d] = op; end
  endtask

  // Entered and left at a negedge; single requester, response consumed immediately.
  task automatic run_op(input int d, input bit s, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [7:0] er, input logic ec, input logic ez,
                        input logic ev, input int lat);
    int n;
    drive_req(d, s, 1'b1, a, b, op);
    #1;
    chk("req_ready", s ? req1_ready[d] : req0_ready[d], 1);
    chk("other_ready", s ? req0_ready[d] : req1_ready[d], 0);
    @(posedge clk); @(negedge clk);
    drive_req(d, s, 1'b0, 8'h00, 8'h00, 2'b00);
    n = 0;
    while (!(s ? rsp1_valid[d] : rsp0_valid[d]) && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    chk("rsp_latency", n, 1 + lat);
    chk("rsp_result", rsp_result[d], er);
    chk("rsp_flags", {rsp_carry[d], rsp_zero[d], rsp_overflow[d]}, {ec, ez, ev});
    chk("other_rsp_valid", s ? rsp0_valid[d] : rsp1_valid[d], 0);
    if (s) rsp1_ready[d] = 1'b1; else rsp0_ready[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp0_ready[d] = 1'b0; rsp1_ready[d] = 1'b0;
    chk("idle_after_rsp", busy[d], 0);
  endtask

  typedef struct {
    bit         s;
    logic [7:0] a, b;
    logic [1:0] op;
    logic [7:0] r;
    logic       c, z, v;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [7:0] held;
    int         cyc, last_cyc, who, any_v;

    tbl[0] = '{1'b0, 8'h7F, 8'h01, 2'b00, 8'h80, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 8'h00, 8'h01, 2'b01, 8'hFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'hF0, 8'h0F, 2'b10, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h0F, 8'h30, 2'b11, 8'h3F, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h80, 8'h01, 2'b01, 8'h7F, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h80, 8'h80, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 8'h05, 8'h05, 2'b01, 8'h00, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    req0_valid = '0; req1_valid = '0; rsp0_ready = '0; rsp1_ready = '0;
    for (int d = 0; d < 2; d++) begin
      drive_req(d, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
      drive_req(d, 1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
    end
    @(negedge clk); @(negedge clk);
    chk("reset_busy", busy[0], 0);
    chk("reset_rsp_valid", {rsp0_valid[0], rsp1_valid[0]}, 0);
    chk("reset_rsp_result", rsp_result[0], 0);
    chk("reset_alu", {alu_a[0], alu_b[0], alu_op[0]}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_op(0, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].r, tbl[i].c, tbl[i].z, tbl[i].v, 1);

    // Tie right after reset goes to req0; then response backpressure while req1 waits.
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; @(negedge clk);
    drive_req(0, 1'b0, 1'b1, 8'h0F, 8'h30, 2'b11);
    drive_req(0, 1'b1, 1'b1, 8'hFF, 8'h3C, 2'b10);
    #1;
    chk("tie_req0_ready", req0_ready[0], 1);
    chk("tie_req1_ready", req1_ready[0], 0);
    @(posedge clk); @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    chk("tie_rsp0_valid", rsp0_valid[0], 1);
    chk("tie_rsp0_result", rsp_result[0], 8'h3F);
    held = rsp_result[0];
    any_v = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      if (!rsp0_valid[0] || rsp_result[0] !== held || req1_ready[0] || !busy[0]) any_v++;
    end
    chk("backpressure_stall", any_v, 0);
    rsp0_ready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp0_ready[0] = 1'b0;
    #1;
    chk("req1_ready_after_release", req1_ready[0], 1);
    @(posedge clk); @(negedge clk);
    drive_req(0, 1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
    @(posedge clk); @(negedge clk); @(posedge clk); @(negedge clk);
    chk("tie_rsp1_valid", rsp1_valid[0], 1);
    chk("tie_rsp1_result", rsp_result[0], 8'h3C);
    rsp1_ready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp1_ready[0] = 1'b0;

    // Continuous contention with responses always consumed: grants alternate every 4 cycles.
    drive_req(0, 1'b0, 1'b1, 8'h0F, 8'h30, 2'b11);
    drive_req(0, 1'b1, 1'b1, 8'hFF, 8'h3C, 2'b10);
    rsp0_ready[0] = 1'b1; rsp1_ready[0] = 1'b1;
    cyc = 0; last_cyc = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      while (!req0_ready[0] && !req1_ready[0] && cyc < 200) begin
        @(posedge clk); @(negedge clk); cyc++; #1;
      end
      who = req1_ready[0] ? 1 : 0;
      chk("alternate_grant", who, k % 2);
      if (k > 0) chk("issue_interval", cyc - last_cyc, 4);
      last_cyc = cyc;
      @(posedge clk); @(negedge clk); cyc++;
    end
    drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    drive_req(0, 1'b1, 1'b0, 8'h00, 8'h00, 2'b00);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rsp0_ready[0] = 1'b0; rsp1_ready[0] = 1'b0;
    chk("contention_result", rsp_result[0], 8'h3C);

    // Reset while in WAIT drops the operation.
    drive_req(0, 1'b0, 1'b1, 8'h55, 8'h22, 2'b00);
    @(posedge clk); @(negedge clk);
    drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    @(posedge clk); @(negedge clk);
    chk("wait_busy", busy[0], 1);
    chk("wait_alu_a", alu_a[0], 8'h55);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy[0], 0);
    chk("rst_alu", {alu_a[0], alu_b[0], alu_op[0]}, 0);
    chk("rst_rsp", {rsp_result[0], rsp_carry[0], rsp_zero[0], rsp_overflow[0]}, 0);
    chk("rst_rsp_valid", {rsp0_valid[0], rsp1_valid[0]}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    any_v = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (rsp0_valid[0] || rsp1_valid[0] || busy[0]) any_v++;
    end
    chk("no_rsp_after_rst", any_v, 0);
    drive_req(0, 1'b0, 1'b1, 8'h01, 8'h01, 2'b00);
    drive_req(0, 1'b1, 1'b1, 8'h01, 8'h01, 2'b00);
    #1;
    chk("post_rst_tie", {req1_ready[0], req0_ready[0]}, 2'b01);
    drive_req(0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    drive_req(0, 1'b1, 1'b0, 8'h00, 8'h00, 2'b00);

    // Latency-3 instance: five operations, three on req0 and two on req1.
    run_op(1, 1'b0, 8'h01, 8'h02, 2'b00, 8'h03, 1'b0, 1'b0, 1'b0, 3);
    run_op(1, 1'b0, 8'h10, 8'h01, 2'b01, 8'h0F, 1'b0, 1'b0, 1'b0, 3);
    run_op(1, 1'b0, 8'h0F, 8'hF0, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0, 3);
    run_op(1, 1'b1, 8'hAA, 8'h0F, 2'b10, 8'h0A, 1'b0, 1'b0, 1'b0, 3);
    run_op(1, 1'b1, 8'h7F, 8'h7F, 2'b00, 8'hFE, 1'b0, 1'b0, 1'b1, 3);
`ifdef ALU_ARB_STATS_EN
    chk("grant_cnt0", grant_cnt0[1], 16'd3);
    chk("grant_cnt1", grant_cnt1[1], 16'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_8bit_arbiter.md
# alu_8bit_arbiter

Round-robin arbiter and sequencer that shares one registered 8-bit ALU between two requesters. The block sits in front of the ALU and accepts one operation at a time over a valid/ready handshake. It drives the ALU operands, waits out the ALU's registered latency, then captures result and flags and returns them to the winning requester over a valid/ready response channel.

## Interface
- ALU_LATENCY, 1, clock edges from the first ISSUE cycle until the ALU outputs hold that result; legal range 1–7.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester N has an operation pending.
- req0_ready / req1_ready  out  1  operation accepted on this edge when asserted together with valid.
- req0_a, req0_b / req1_a, req1_b  in  8  operands.
- req0_op / req1_op  in  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- rsp0_valid / rsp1_valid  out  1  response pending for requester N.
- rsp0_ready / rsp1_ready  in  1  requester N consumes the response.
- rsp_result  out  8  shared response data.
- rsp_carry, rsp_zero, rsp_overflow  out  1  shared response flags.
- alu_a, alu_b  out  8  ALU operands.
- alu_op  out  2  ALU operation select.
- alu_result  in  8  ALU result.
- alu_carry, alu_zero, alu_overflow  in  1  ALU flags.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - grant = the only valid requester; if both are valid, grant = the requester other than last_grant.
  - reqN_ready = (state==IDLE) && grant==N; combinational from reqN_valid. Never high for both requesters.
  - On accept: latch a/b/op into operand registers, record grant, go to ISSUE.
- **ISSUE**
  - alu_a/alu_b/alu_op always drive the operand registers, so they hold stable until the next accept.
  - Load wait counter with ALU_LATENCY-1, go to WAIT.
- **WAIT**
  - If counter==0: latch alu_result/carry/zero/overflow into the response registers and go to RESP.
  - Otherwise decrement the counter.
- **RESP**
  - rsp{grant}_valid=1; the other rsp valid stays 0.
  - rsp_* stays stable until the handshake.
  - On rsp{grant}_ready: clear valid, set last_grant=grant, go to IDLE.
- Requesters hold valid and operands stable until ready. A non-granted requester simply waits.
- The arbiter passes flags through unchanged. It does no arithmetic of its own.
- reqN_ready never asserts outside IDLE, so a request arriving mid-operation waits for the return to IDLE.
- Reset, including reset mid-operation:
  - state=IDLE, last_grant=1 (req0 wins the first tie).
  - All rsp_* and alu_* outputs = 0; counter=0; busy=0.
  - Any in-flight operation is dropped with no response.

## Timing
- Accept edge = T0. ALU samples operands at T1 (end of ISSUE).
- rsp valid rises on edge T0+1+ALU_LATENCY. With the default that is T0+2.
- Minimum issue interval is 3+ALU_LATENCY cycles when rsp_ready is held high. The earliest next accept is the cycle after the response handshake.
- Response backpressure stalls the FSM in RESP indefinitely; nothing is lost.
- Under continuous contention, grants strictly alternate 0,1,0,1.

## Configuration
- ALU_ARB_STATS_EN defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each).
  - Each counter increments on every accept for its requester and saturates at 0xFFFF.
  - Counters clear on reset.
- ALU_ARB_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Single ADD, req0, A=0x7F, B=0x01 -> rsp0_valid at T0+2 with result 0x80, carry 0, zero 0, overflow 1. rsp1_valid stays 0.
- Single SUB, req1, A=0x00, B=0x01 -> result 0xFF, carry 1, overflow 0, zero 0. AND 0xF0&0x0F -> result 0x00, zero 1.
- Both requesters valid from reset (req0 OR 0x0F|0x30, req1 AND 0xFF&0x3C) -> req0 served first (0x3F), then req1 (0x3C). Continuous requests alternate grants.
- Hold rsp0_ready=0 for 5 cycles while req1 is valid -> FSM stays in RESP, rsp_result stays stable, req1_ready stays 0. Release rsp0_ready -> req1 is accepted the next cycle.
- Pull rst_n low while in WAIT -> all outputs go 0 immediately and no response is issued. After release, the first tie goes to req0.
- ALU_LATENCY=3 with ALU_ARB_STATS_EN defined, 3 ops on req0 and 2 on req1 -> rsp valid arrives at T0+4; final grant_cnt0=3, grant_cnt1=2.
